// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS controller: sequences FETCH/DECODE/EXEC/MEM/WB over one shared
// memory port and drives ALU, PC, register-file and byte-lane write controls.
module mips_multicycle_ctrl #(
    parameter int BYTE_LANES = 4,
    parameter int LANE_W     = $clog2(BYTE_LANES)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [31:0]           i_instr_in,
    input  logic                  i_mem_ready,
    input  logic [LANE_W-1:0]     i_mem_addr_lo,
    input  logic                  i_alu_zero,
    output logic                  o_mem_req,
    output logic                  o_mem_sel,
    output logic [BYTE_LANES-1:0] o_data_mem_wren,
    output logic                  o_ir_wren,
    output logic                  o_reg_file_wren,
    output logic [1:0]            o_reg_file_rmux_select,
    output logic [1:0]            o_reg_file_dmux_select,
    output logic                  o_alu_mux_select,
    output logic [3:0]            o_alu_control,
    output logic [2:0]            o_pc_control,
    output logic                  o_instr_done,
    output logic                  o_illegal_op
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] PC_HOLD = 3'b000;
    localparam logic [2:0] PC_INC  = 3'b001;
    localparam logic [2:0] PC_BR   = 3'b010;
    localparam logic [2:0] PC_JMP  = 3'b011;

    localparam logic [3:0] ALU_ADD  = 4'b1010;
    localparam logic [3:0] ALU_SUB  = 4'b1011;
    localparam logic [3:0] ALU_NONE = 4'b1111;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_ir;
    logic        r_illegal;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_unused_ir;
    logic        w_is_r, w_is_addi, w_is_lw, w_is_sw, w_is_sb;
    logic        w_is_beq, w_is_bne, w_is_j, w_is_jal;
    logic        w_is_mem, w_uses_imm, w_funct_ok, w_legal, w_take;
    logic [3:0]  w_rfunct_alu;
    logic [3:0]  w_exec_alu;
    logic [BYTE_LANES-1:0] w_sb_lane;
    logic [BYTE_LANES-1:0] w_store_mask;

    assign w_op        = r_ir[31:26];
    assign w_funct     = r_ir[5:0];
    // Register fields and immediates are consumed by the datapath's own IR copy.
    assign w_unused_ir = ^r_ir[25:6];

    assign w_is_r     = (w_op == OP_RTYPE);
    assign w_is_addi  = (w_op == OP_ADDI);
    assign w_is_lw    = (w_op == OP_LW);
    assign w_is_sw    = (w_op == OP_SW);
    assign w_is_sb    = (w_op == OP_SB);
    assign w_is_beq   = (w_op == OP_BEQ);
    assign w_is_bne   = (w_op == OP_BNE);
    assign w_is_j     = (w_op == OP_J);
    assign w_is_jal   = (w_op == OP_JAL);
    assign w_is_mem   = w_is_lw | w_is_sw | w_is_sb;
    assign w_uses_imm = w_is_addi | w_is_mem;
    assign w_take     = (w_is_beq & i_alu_zero) | (w_is_bne & ~i_alu_zero);

    always_comb begin
        w_rfunct_alu = ALU_NONE;
        w_funct_ok   = 1'b1;
        case (w_funct)
            6'h24:   w_rfunct_alu = 4'b0000;
            6'h25:   w_rfunct_alu = 4'b0001;
            6'h21:   w_rfunct_alu = 4'b0010;
            6'h26:   w_rfunct_alu = 4'b0011;
            6'h27:   w_rfunct_alu = 4'b0100;
            6'h23:   w_rfunct_alu = 4'b0110;
            6'h2A:   w_rfunct_alu = 4'b0111;
            6'h00:   w_rfunct_alu = 4'b1000;
            6'h02:   w_rfunct_alu = 4'b1001;
            6'h20:   w_rfunct_alu = 4'b1010;
            6'h22:   w_rfunct_alu = 4'b1011;
            default: w_funct_ok   = 1'b0;
        endcase
    end

    assign w_legal = (w_is_r & w_funct_ok) | w_uses_imm | w_is_beq | w_is_bne
                   | w_is_j | w_is_jal;

    always_comb begin
        w_exec_alu = ALU_NONE;
        if (w_is_r)
            w_exec_alu = w_rfunct_alu;
        else if (w_uses_imm)
            w_exec_alu = ALU_ADD;
        else if (w_is_beq | w_is_bne)
            w_exec_alu = ALU_SUB;
    end

    assign w_sb_lane = BYTE_LANES'(1) << i_mem_addr_lo;

    always_comb begin
        w_store_mask = '0;
        if (w_is_sw)
            w_store_mask = '1;
        else if (w_is_sb)
            w_store_mask = w_sb_lane;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_FETCH && i_mem_ready)
                r_ir <= i_instr_in;
            if (r_state == S_DECODE && !w_legal)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   w_next_state = S_FETCH;
            S_FETCH:  if (i_mem_ready) w_next_state = S_DECODE;
            S_DECODE: w_next_state = w_legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (w_is_r | w_is_addi)
                    w_next_state = S_WB;
                else if (w_is_mem)
                    w_next_state = S_MEM;
                else
                    w_next_state = S_FETCH;
            end
            S_MEM:    if (i_mem_ready) w_next_state = w_is_lw ? S_WB : S_FETCH;
            S_WB:     w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_mem_req              = 1'b0;
        o_mem_sel              = 1'b0;
        o_data_mem_wren        = '0;
        o_ir_wren              = 1'b0;
        o_reg_file_wren        = 1'b0;
        o_reg_file_rmux_select = 2'b00;
        o_reg_file_dmux_select = 2'b00;
        o_alu_mux_select       = 1'b0;
        o_alu_control          = ALU_NONE;
        o_pc_control           = PC_HOLD;
        o_instr_done           = 1'b0;
        case (r_state)
            S_IDLE: o_alu_control = 4'b0000;
            S_FETCH: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    o_ir_wren    = 1'b1;
                    o_pc_control = PC_INC;
                end
            end
            S_EXEC: begin
                o_alu_control    = w_exec_alu;
                o_alu_mux_select = w_uses_imm;
                if (w_is_beq | w_is_bne) begin
                    o_instr_done = 1'b1;
                    if (w_take)
                        o_pc_control = PC_BR;
                end
                if (w_is_j | w_is_jal) begin
                    o_pc_control = PC_JMP;
                    o_instr_done = 1'b1;
                end
                // JAL links r31 <- PC in the same cycle it redirects.
                if (w_is_jal) begin
                    o_reg_file_wren        = 1'b1;
                    o_reg_file_rmux_select = 2'b10;
                    o_reg_file_dmux_select = 2'b10;
                end
            end
            S_MEM: begin
                o_mem_req       = 1'b1;
                o_mem_sel       = 1'b1;
                o_data_mem_wren = w_store_mask;
                if (i_mem_ready && !w_is_lw)
                    o_instr_done = 1'b1;
            end
            S_WB: begin
                o_reg_file_wren        = 1'b1;
                o_instr_done           = 1'b1;
                o_reg_file_rmux_select = w_is_r ? 2'b00 : 2'b01;
                o_reg_file_dmux_select = w_is_lw ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
    end

    assign o_illegal_op = r_illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-instruction phase model checked every
// cycle, plus literal latency and control-value expectations.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_sel;
        logic [3:0] wren;
        logic       ir_wren;
        logic       rf_wren;
        logic [1:0] rmux;
        logic [1:0] dmux;
        logic       alu_mux;
        logic [3:0] alu;
        logic [2:0] pc;
        logic       done;
        logic       illegal;
    } out_t;

    logic        clk = 1'b0;
    logic        i_reset_n, i_mem_ready, i_alu_zero;
    logic [31:0] i_instr_in;
    logic [1:0]  i_mem_addr_lo;
    logic        o_mem_req, o_mem_sel, o_ir_wren, o_reg_file_wren, o_alu_mux_select;
    logic        o_instr_done, o_illegal_op;
    logic [3:0]  o_data_mem_wren, o_alu_control;
    logic [1:0]  o_reg_file_rmux_select, o_reg_file_dmux_select;
    logic [2:0]  o_pc_control;

    mips_multicycle_ctrl #(.BYTE_LANES(4), .LANE_W(2)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_instr_in(i_instr_in),
        .i_mem_ready(i_mem_ready), .i_mem_addr_lo(i_mem_addr_lo), .i_alu_zero(i_alu_zero),
        .o_mem_req(o_mem_req), .o_mem_sel(o_mem_sel), .o_data_mem_wren(o_data_mem_wren),
        .o_ir_wren(o_ir_wren), .o_reg_file_wren(o_reg_file_wren),
        .o_reg_file_rmux_select(o_reg_file_rmux_select),
        .o_reg_file_dmux_select(o_reg_file_dmux_select),
        .o_alu_mux_select(o_alu_mux_select), .o_alu_control(o_alu_control),
        .o_pc_control(o_pc_control), .o_instr_done(o_instr_done), .o_illegal_op(o_illegal_op)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    out_t  exp_o;
    logic  exp_valid = 1'b0;
    string exp_name = "";
    int    cyc, done_at, ndone;
    out_t  act_h [0:31];

    localparam logic [31:0] GARBAGE = 32'hFFFF_FFFF;
    localparam logic [31:0] I_ADD   = 32'h012A4020;
    localparam logic [31:0] I_LW    = 32'h8D280004;
    localparam logic [31:0] I_SB    = 32'hA1280003;
    localparam logic [31:0] I_SW    = 32'hAD280004;
    localparam logic [31:0] I_BEQ   = 32'h11280002;
    localparam logic [31:0] I_BNE   = 32'h15280002;
    localparam logic [31:0] I_ADDI  = 32'h21280005;
    localparam logic [31:0] I_J     = 32'h08000010;
    localparam logic [31:0] I_JAL   = 32'h0C000010;

    logic [31:0] r_ins [0:9] = '{32'h012A4024, 32'h012A4025, 32'h012A4021, 32'h012A4026,
                                 32'h012A4027, 32'h012A4023, 32'h012A402A, 32'h012A4000,
                                 32'h012A4002, 32'h012A4022};
    logic [3:0]  r_alu [0:9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                                 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1011};

    function automatic out_t dut_out();
        return {o_mem_req, o_mem_sel, o_data_mem_wren, o_ir_wren, o_reg_file_wren,
                o_reg_file_rmux_select, o_reg_file_dmux_select, o_alu_mux_select,
                o_alu_control, o_pc_control, o_instr_done, o_illegal_op};
    endfunction

    // ---- behavioural model: what each phase of an instruction must show ----
    function automatic logic [3:0] alu_code(input logic [31:0] ins);
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h24: return 4'b0000;  6'h25: return 4'b0001;  6'h21: return 4'b0010;
                6'h26: return 4'b0011;  6'h27: return 4'b0100;  6'h23: return 4'b0110;
                6'h2A: return 4'b0111;  6'h00: return 4'b1000;  6'h02: return 4'b1001;
                6'h20: return 4'b1010;  6'h22: return 4'b1011;
                default: return 4'b1111;
            endcase
            6'h08, 6'h23, 6'h2B, 6'h28: return 4'b1010;
            6'h04, 6'h05: return 4'b1011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic legal(input logic [31:0] ins);
        case (ins[31:26])
            6'h00: return alu_code(ins) != 4'b1111;
            6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B, 6'h28: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic out_t e_idle();
        out_t e = '0;
        return e;
    endfunction

    function automatic out_t e_decode();
        out_t e = '0;
        e.alu = 4'hF;
        return e;
    endfunction

    function automatic out_t e_halt();
        out_t e = e_decode();
        e.illegal = 1'b1;
        return e;
    endfunction

    function automatic out_t e_fetch(input logic rdy);
        out_t e = e_decode();
        e.mem_req = 1'b1;
        e.ir_wren = rdy;
        e.pc      = rdy ? 3'b001 : 3'b000;
        return e;
    endfunction

    function automatic out_t e_exec(input logic [31:0] ins, input logic zero);
        out_t e = '0;
        e.alu = alu_code(ins);
        case (ins[31:26])
            6'h08, 6'h23, 6'h2B, 6'h28: e.alu_mux = 1'b1;
            6'h04: begin e.done = 1'b1; e.pc = zero ? 3'b010 : 3'b000; end
            6'h05: begin e.done = 1'b1; e.pc = zero ? 3'b000 : 3'b010; end
            6'h02: begin e.done = 1'b1; e.pc = 3'b011; end
            6'h03: begin
                e.done = 1'b1; e.pc = 3'b011; e.rf_wren = 1'b1; e.rmux = 2'b10; e.dmux = 2'b10;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic out_t e_mem(input logic [31:0] ins, input logic rdy, input logic [1:0] lo);
        out_t e = e_decode();
        e.mem_req = 1'b1;
        e.mem_sel = 1'b1;
        if (ins[31:26] == 6'h2B) e.wren = 4'b1111;
        if (ins[31:26] == 6'h28) e.wren = 4'(1 << lo);
        e.done = rdy && (ins[31:26] != 6'h23);
        return e;
    endfunction

    function automatic out_t e_wb(input logic [31:0] ins);
        out_t e = e_decode();
        e.rf_wren = 1'b1;
        e.done    = 1'b1;
        e.rmux    = (ins[31:26] == 6'h00) ? 2'b00 : 2'b01;
        e.dmux    = (ins[31:26] == 6'h23) ? 2'b01 : 2'b00;
        return e;
    endfunction

    // ---- per-cycle comparison against the model ----
    always @(negedge clk) begin
        if (exp_valid) begin
            total++;
            if (dut_out() !== exp_o) begin
                bad++;
                $display("FAIL %s t=%0t: got %h want %h", exp_name, $time, dut_out(), exp_o);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Called at posedge+1; drives one cycle and records what the DUT showed.
    task automatic step(input string nm, input out_t e, input logic rdy, input logic zero,
                        input logic [1:0] lo, input logic [31:0] ins);
        i_mem_ready   = rdy;
        i_alu_zero    = zero;
        i_mem_addr_lo = lo;
        i_instr_in    = ins;
        exp_o         = e;
        exp_name      = nm;
        exp_valid     = 1'b1;
        cyc++;
        @(negedge clk);
        if (cyc < 32) act_h[cyc] = dut_out();
        if (o_instr_done) begin
            done_at = cyc;
            ndone++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string nm, input logic [31:0] ins, input int fw, input int mw,
                             input logic zero, input logic [1:0] lo, input int lat_want);
        logic [5:0] op;
        op = ins[31:26];
        cyc = 0; done_at = 0; ndone = 0;
        for (int i = 0; i <= fw; i++)
            step({nm, ":fetch"}, e_fetch(i == fw), i == fw, 1'b0, 2'd0, (i == fw) ? ins : GARBAGE);
        step({nm, ":decode"}, e_decode(), 1'b1, zero, lo, GARBAGE);
        if (!legal(ins)) begin
            for (int i = 0; i < 4; i++)
                step({nm, ":halt"}, e_halt(), 1'($urandom_range(0, 1)), zero, lo, GARBAGE);
            chk({nm, ":no_done"}, ndone, 0);
            return;
        end
        step({nm, ":exec"}, e_exec(ins, zero), 1'b1, zero, lo, GARBAGE);
        if (op == 6'h23 || op == 6'h2B || op == 6'h28)
            for (int i = 0; i <= mw; i++)
                step({nm, ":mem"}, e_mem(ins, i == mw, lo), i == mw, zero, lo, GARBAGE);
        if (op == 6'h00 || op == 6'h08 || op == 6'h23)
            step({nm, ":wb"}, e_wb(ins), 1'b1, zero, lo, GARBAGE);
        chk({nm, ":latency"}, done_at, lat_want);
        chk({nm, ":one_done"}, ndone, 1);
    endtask

    task automatic reset_from_halt(input string nm);
        cyc = 0;
        i_reset_n = 1'b0;
        step({nm, ":rst_edge"}, e_halt(), 1'b1, 1'b0, 2'd0, GARBAGE);
        step({nm, ":rst_idle"}, e_idle(), 1'b1, 1'b0, 2'd0, GARBAGE);
        i_reset_n = 1'b1;
        step({nm, ":idle"}, e_idle(), 1'b1, 1'b0, 2'd0, GARBAGE);
        chk({nm, ":illegal_cleared"}, act_h[2].illegal, 0);
    endtask

    initial begin
        i_reset_n = 1'b0; i_mem_ready = 1'b0; i_alu_zero = 1'b0;
        i_mem_addr_lo = 2'd0; i_instr_in = '0;
        repeat (2) @(posedge clk);
        #1;
        cyc = 0;
        step("reset", e_idle(), 1'b1, 1'b0, 2'd0, GARBAGE);
        step("reset", e_idle(), 1'b1, 1'b0, 2'd0, GARBAGE);
        chk("reset_all_zero", act_h[1], 0);
        i_reset_n = 1'b1;
        step("idle_release", e_idle(), 1'b1, 1'b0, 2'd0, GARBAGE);

        run_instr("add", I_ADD, 0, 0, 1'b0, 2'd0, 4);
        chk("add_alu_exec", act_h[3].alu, 4'b1010);
        chk("add_wb_wren_rmux", {act_h[4].rf_wren, act_h[4].rmux}, 3'b100);

        run_instr("lw", I_LW, 0, 2, 1'b0, 2'd0, 7);
        chk("lw_mem_req_3cyc", {act_h[4].mem_req, act_h[5].mem_req, act_h[6].mem_req,
                                act_h[7].mem_req}, 4'b1110);
        chk("lw_wb_muxes", {act_h[7].dmux, act_h[7].rmux}, 4'b0101);

        run_instr("sb", I_SB, 0, 0, 1'b0, 2'd3, 4);
        chk("sb_wren_mem", act_h[4].wren, 4'b1000);
        chk("sb_wren_exec", act_h[3].wren, 4'b0000);

        run_instr("sw", I_SW, 0, 1, 1'b0, 2'd2, 5);
        chk("sw_wren_mem", {act_h[4].wren, act_h[5].wren}, 8'hFF);

        run_instr("beq_t", I_BEQ, 0, 0, 1'b1, 2'd0, 3);
        chk("beq_taken_pc", act_h[3].pc, 3'b010);
        run_instr("beq_nt", I_BEQ, 0, 0, 1'b0, 2'd0, 3);
        chk("beq_not_taken_pc", act_h[3].pc, 3'b000);
        run_instr("bne_t", I_BNE, 0, 0, 1'b0, 2'd0, 3);
        chk("bne_taken_pc", act_h[3].pc, 3'b010);
        run_instr("bne_nt", I_BNE, 1, 0, 1'b1, 2'd0, 4);
        chk("bne_not_taken_pc", act_h[4].pc, 3'b000);

        run_instr("addi", I_ADDI, 2, 0, 1'b0, 2'd0, 6);
        chk("addi_exec_alu_imm", {act_h[5].alu, act_h[5].alu_mux}, 5'b10101);
        chk("addi_wb_rmux", act_h[6].rmux, 2'b01);

        for (int k = 0; k < 10; k++) begin
            run_instr("rtype", r_ins[k], 0, 0, 1'b0, 2'd0, 4);
            chk("rtype_alu_code", act_h[3].alu, r_alu[k]);
        end

        run_instr("j", I_J, 0, 0, 1'b0, 2'd0, 3);
        chk("j_pc", {act_h[3].pc, act_h[3].rf_wren}, 4'b0110);
        run_instr("jal", I_JAL, 0, 0, 1'b0, 2'd0, 3);
        chk("jal_link", {act_h[3].pc, act_h[3].rf_wren, act_h[3].rmux, act_h[3].dmux},
            8'b011_1_10_10);

        // Reset held 3 edges while SW sits in MEM waiting on memory.
        cyc = 0;
        step("ab:fetch", e_fetch(1'b0), 1'b0, 1'b0, 2'd0, GARBAGE);
        step("ab:fetch", e_fetch(1'b1), 1'b1, 1'b0, 2'd0, I_SW);
        step("ab:decode", e_decode(), 1'b0, 1'b0, 2'd0, GARBAGE);
        step("ab:exec", e_exec(I_SW, 1'b0), 1'b0, 1'b0, 2'd0, GARBAGE);
        step("ab:mem", e_mem(I_SW, 1'b0, 2'd0), 1'b0, 1'b0, 2'd0, GARBAGE);
        i_reset_n = 1'b0;
        step("ab:mem_rst", e_mem(I_SW, 1'b0, 2'd0), 1'b0, 1'b0, 2'd0, GARBAGE);
        step("ab:idle", e_idle(), 1'b1, 1'b0, 2'd0, GARBAGE);
        step("ab:idle", e_idle(), 1'b1, 1'b0, 2'd0, GARBAGE);
        i_reset_n = 1'b1;
        step("ab:idle_rel", e_idle(), 1'b1, 1'b0, 2'd0, GARBAGE);
        chk("abort_wren_before", act_h[6].wren, 4'b1111);
        chk("abort_all_zero", act_h[7], 0);
        run_instr("add_after_abort", I_ADD, 0, 0, 1'b0, 2'd0, 4);

        run_instr("ill_op", 32'hFC000000, 0, 0, 1'b0, 2'd0, -1);
        chk("ill_flag_decode", act_h[2].illegal, 0);
        chk("ill_flag_halt", act_h[3].illegal, 1);
        chk("ill_no_mem_req", {act_h[3].mem_req, act_h[4].mem_req, act_h[5].mem_req,
                               act_h[6].mem_req}, 4'b0000);
        reset_from_halt("ill_op");
        run_instr("jal_after_ill", I_JAL, 0, 0, 1'b0, 2'd0, 3);

        run_instr("ill_funct", 32'h012A403F, 0, 0, 1'b0, 2'd0, -1);
        chk("ill_funct_flag", act_h[4].illegal, 1);
        reset_from_halt("ill_funct");
        run_instr("lw_after_ill", I_LW, 0, 0, 1'b0, 2'd0, 5);

        exp_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
